// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
//
// Write-side pointer and full-flag controller for the dual-clock FIFO. It
// takes the two-flop-synchronized Gray read pointer from the read-to-write
// synchronizer. It keeps a binary write pointer with one wrap bit and exports
// the registered Gray write pointer to the read domain. It also produces a
// registered full flag and a sticky overflow flag. When the level feature is
// built, it adds a fill level and an almost-full flag.
//
// Optional feature macro: WPTR_FULL_LEVEL_EN
//   defined   : Gray-to-binary of wq2_rptr, level subtractor, wlevel and
//               walmost_full registers are built.
//   undefined : wlevel is tied to 0 and walmost_full follows wfull.
//
// Parameters
//   ASIZE      FIFO address width, depth = 2**ASIZE (ASIZE >= 2)
//   AF_MARGIN  walmost_full when free slots <= AF_MARGIN (1 .. 2**ASIZE-1)
//
// Ports
//   wclk          in   write-domain clock
//   wrst_n        in   asynchronous active-low reset
//   winc          in   write request, accepted when wfull = 0
//   wq2_rptr      in   synchronized Gray read pointer [ASIZE:0]
//   wovf_clr      in   clears wovf (a same-cycle set wins)
//   waddr         out  binary RAM write address [ASIZE-1:0] (decoded from wbin)
//   wptr          out  registered Gray write pointer [ASIZE:0]
//   wfull         out  registered full flag
//   wovf          out  sticky overflow: write attempted while full
//   wlevel        out  registered fill level [ASIZE:0], 0 .. 2**ASIZE
//   walmost_full  out  registered almost-full flag
// -----------------------------------------------------------------------------
module wptr_full_ctrl #(
  parameter int ASIZE     = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             wovf,
  output logic [ASIZE:0]   wlevel,
  output logic             walmost_full
);

  localparam bit PARAMS_OK = (ASIZE >= 2) && (AF_MARGIN >= 1) &&
                             (AF_MARGIN <= (2 ** ASIZE) - 1);

  // Elaboration-time guard against illegal parameter sets.
  if (!PARAMS_OK) begin : g_param_check
    $error("wptr_full_ctrl: illegal ASIZE/AF_MARGIN");
  end

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbinnext;
  logic [ASIZE:0] wgraynext;
  logic           winc_ok;
  logic           wfull_val;

  // A write is only accepted while not full; a blocked write leaves the
  // pointers untouched.
  assign winc_ok   = winc & ~wfull;
  assign wbinnext  = wbin + {{ASIZE{1'b0}}, winc_ok};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Full when the next write pointer equals the read pointer one lap ahead.
  // In Gray code, that means the two MSBs are inverted and the rest are equal.
  assign wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

  assign waddr = wbin[ASIZE-1:0];

  // NOTE: every register here uses non-blocking assignments and an async
  // reset branch. Then all flops sample the same pre-edge values, and
  // wrst_n=0 clears them at once without waiting for wclk.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbinnext;
      wptr  <= wgraynext;
      wfull <= wfull_val;
    end
  end

  // Sticky overflow. The set term is checked first, so a new overflow is
  // not lost to a concurrent clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

`ifdef WPTR_FULL_LEVEL_EN
  localparam logic [ASIZE:0] AF_THRESH = (ASIZE + 1)'((2 ** ASIZE) - AF_MARGIN);

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] level_next;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  // NOTE: this always_comb assigns a default before the loop, so every bit
  // is always written and no latch can be inferred.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Modulo 2**(ASIZE+1) difference. It stays correct across pointer wrap.
  // It uses the same wbinnext and wq2_rptr as wfull_val, so level,
  // almost-full and full agree in every cycle.
  assign level_next = wbinnext - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_next;
      walmost_full <= (level_next >= AF_THRESH);
    end
  end
`else
  assign wlevel       = '0;
  assign walmost_full = wfull;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
//
// Self-checking bench for wptr_full_ctrl with ASIZE=4 and AF_MARGIN=2.
//
// A table of {inputs, expected full/ovf/level} records drives reset, fill,
// overflow, clear and drain. Hand-written sequences then cover the wrap and
// a mid-operation reset.
//
// Expected values come from a binary-count model: the bench tracks the write
// count and the read count in binary and drives wq2_rptr as the Gray code of
// the read count. On each step, the expected values are pushed to a queue.
// They are popped and compared 1 ns after the active wclk edge.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

  localparam int ASIZE     = 4;
  localparam int AF_MARGIN = 2;
  localparam int DEPTH     = 1 << ASIZE;
  localparam int PMASK     = (2 * DEPTH) - 1;

  logic             wclk;
  logic             wrst_n;
  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic             wovf_clr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             wovf;
  logic [ASIZE:0]   wlevel;
  logic             walmost_full;

  wptr_full_ctrl #(.ASIZE(ASIZE), .AF_MARGIN(AF_MARGIN)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wovf         (wovf),
    .wlevel       (wlevel),
    .walmost_full (walmost_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    bit winc;
    bit clr;
    int rb;      // binary read count; wq2_rptr is driven with its Gray code
    int lvl;     // expected level with the feature built
    bit full;
    bit ovf;
  } vec_t;

  typedef struct {
    int waddr;
    int wptr;
    int full;
    int ovf;
    int level;
    int almost;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int  m_wb   = 0;
  bit  m_full = 1'b0;
  bit  m_ovf  = 1'b0;
  int  m_rb   = 0;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & PMASK;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_level(input int lvl);
`ifdef WPTR_FULL_LEVEL_EN
    return lvl;
`else
    return 0 * lvl;
`endif
  endfunction

  function automatic int exp_almost(input int lvl, input bit full);
`ifdef WPTR_FULL_LEVEL_EN
    return (lvl >= DEPTH - AF_MARGIN) ? 1 : 0;
`else
    return (lvl < 0) ? 0 : int'(full);
`endif
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".waddr"},        int'(waddr),        e.waddr);
    check({tag, ".wptr"},         int'(wptr),         e.wptr);
    check({tag, ".wfull"},        int'(wfull),        e.full);
    check({tag, ".wovf"},         int'(wovf),         e.ovf);
    check({tag, ".wlevel"},       int'(wlevel),       e.level);
    check({tag, ".walmost_full"}, int'(walmost_full), e.almost);
  endtask

  // One wclk cycle. Inputs are driven at negedge, and the model's post-edge
  // expectation is pushed to the scoreboard. The outputs are popped and
  // compared 1 ns after posedge. If use_tbl is set, the table expectations
  // for level/full/ovf override the model.
  task automatic step(input string tag, input bit winc_i, input bit clr_i,
                      input int rb_i, input bit use_tbl, input int t_lvl,
                      input bit t_full, input bit t_ovf);
    exp_t e;
    int   lvl;
    bit   ok;
    @(negedge wclk);
    winc     = winc_i;
    wovf_clr = clr_i;
    m_rb     = rb_i & PMASK;
    wq2_rptr = (ASIZE + 1)'(gray(m_rb));

    ok     = winc_i && !m_full;
    m_ovf  = (winc_i && m_full) ? 1'b1 : (clr_i ? 1'b0 : m_ovf);
    m_wb   = (m_wb + int'(ok)) & PMASK;
    lvl    = (m_wb - m_rb) & PMASK;
    m_full = (lvl == DEPTH);

    if (use_tbl) begin
      lvl    = t_lvl;
      m_full = t_full;
      m_ovf  = t_ovf;
    end

    e.waddr  = m_wb & (DEPTH - 1);
    e.wptr   = gray(m_wb);
    e.full   = int'(m_full);
    e.ovf    = int'(m_ovf);
    e.level  = exp_level(lvl);
    e.almost = exp_almost(lvl, m_full);
    sb_q.push_back(e);

    @(posedge wclk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      compare_outputs(tag, sb_q.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    exp_t z;
    z.waddr = 0; z.wptr = 0; z.full = 0; z.ovf = 0; z.level = 0; z.almost = 0;
    compare_outputs(tag, z);
  endtask

  function automatic void add_vec(input bit w, input bit c, input int rb,
                                  input int lvl, input bit full, input bit ovf);
    vec_t v;
    v.winc = w; v.clr = c; v.rb = rb; v.lvl = lvl; v.full = full; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Watchdog: the bench must terminate on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    for (int i = 1; i <= 13; i++) add_vec(1'b1, 1'b0, 0, i, 1'b0, 1'b0);  // fill to 13
    add_vec(1'b1, 1'b0, 0, 14, 1'b0, 1'b0);  // almost-full threshold
    add_vec(1'b1, 1'b0, 0, 15, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 0, 16, 1'b1, 1'b0);  // 16th write raises full
    add_vec(1'b1, 1'b0, 0, 16, 1'b1, 1'b1);  // write while full -> overflow
    add_vec(1'b1, 1'b1, 0, 16, 1'b1, 1'b1);  // clear + new overflow: set wins
    add_vec(1'b0, 1'b1, 0, 16, 1'b1, 1'b0);  // clear alone
    add_vec(1'b0, 1'b0, 1, 15, 1'b0, 1'b0);  // drain one slot
    add_vec(1'b1, 1'b0, 1, 16, 1'b1, 1'b0);  // refill
    add_vec(1'b0, 1'b0, 17, 0, 1'b0, 1'b0);  // reader catches up

    // ---------------- reset with winc held high ----------------
    winc     = 1'b1;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    wrst_n   = 1'b0;
    #1;
    check_all_zero("reset_immediate");
    repeat (2) @(posedge wclk);
    #1;
    check_all_zero("reset_held");
    @(negedge wclk);
    winc   = 1'b0;
    wrst_n = 1'b1;

    // ---------------- table-driven run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].winc, vecs[i].clr, vecs[i].rb,
           1'b1, vecs[i].lvl, vecs[i].full, vecs[i].ovf);
    end

    // ---------------- wrap: write/read to 30, then 4 more writes ----------------
    // The reader tracks the writer, so every step sees level 1.
    while (m_wb != 30) begin
      step("preload", 1'b1, 1'b0, m_wb, 1'b0, 0, 1'b0, 1'b0);
    end
    step("preload_catchup", 1'b0, 1'b0, 30, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      // wbin goes 31, 0, 1, 2; level 1..4; no spurious full
      step($sformatf("wrap%0d", i), 1'b1, 1'b0, 30, 1'b1, i, 1'b0, 1'b0);
    end
    check("wrap.wbin_wrapped", int'(waddr), 2);

    // ---------------- pessimistic full: reader progress held back ----------------
    while (!m_full) begin
      step("refill", 1'b1, 1'b0, 30, 1'b0, 0, 1'b0, 1'b0);
    end
    step("full_hold", 1'b0, 1'b0, 30, 1'b0, 0, 1'b0, 1'b0);
    step("full_release", 1'b0, 1'b0, 31, 1'b0, 0, 1'b0, 1'b0);

    // ---------------- mid-operation async reset ----------------
    @(negedge wclk);
    winc = 1'b1;
    #2;
    wrst_n = 1'b0;
    #1;
    check_all_zero("midreset_immediate");
    @(posedge wclk);
    #1;
    check_all_zero("midreset_held");
    @(negedge wclk);
    wrst_n = 1'b1;
    winc   = 1'b0;
    m_wb = 0; m_full = 1'b0; m_ovf = 1'b0; m_rb = 0;
    step("post_reset_write", 1'b1, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and full-flag controller for the dual-clock FIFO in the video-DDR path. It sits directly downstream of the read-to-write pointer synchronizer and consumes its two-flop-synchronized Gray read pointer. It maintains the binary write address and the Gray write pointer exported to the read domain. It also generates a registered full flag, a sticky overflow flag and, optionally, a fill level with an almost-full flag.

## Interface
Parameters:
- ASIZE, 4, FIFO address width; depth = 2^ASIZE; legal range ASIZE >= 2.
- AF_MARGIN, 2, walmost_full asserts when free slots <= AF_MARGIN; legal range 1 .. 2^ASIZE-1.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  asynchronous, active-low reset.
- winc  in  1  write request; a write is accepted when winc=1 and wfull=0.
- wq2_rptr  in  ASIZE+1  synchronized Gray read pointer.
- wovf_clr  in  1  clears wovf.
- waddr  out  ASIZE  binary RAM write address.
- wptr  out  ASIZE+1  registered Gray write pointer, to the write-to-read synchronizer.
- wfull  out  1  registered FIFO-full flag.
- wovf  out  1  sticky overflow: a write was attempted while full.
- wlevel  out  ASIZE+1  registered fill level, 0 .. 2^ASIZE.
- walmost_full  out  1  registered almost-full flag.

## Operation
- Internal state: wbin[ASIZE:0], a binary write pointer with one wrap bit.
- Write pointer update:
  - winc_ok = winc & ~wfull.
  - wbinnext = wbin + winc_ok, modulo 2^(ASIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - On every wclk edge: wbin <= wbinnext and wptr <= wgraynext.
  - waddr = wbin[ASIZE-1:0], a direct decode of the register.
- Full detection:
  - wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}).
  - wfull <= wfull_val.
- Overflow flag:
  - Sets on any edge where winc=1 and wfull=1.
  - Clears on wovf_clr=1.
  - Set and clear in the same cycle: set wins.
  - A write attempted while full does not change wbin, waddr or wptr.
- Full is pessimistic. Read-side progress reaches this block only through the synchronizer, so wfull may stay high for up to 3 wclk after the read actually frees a slot. It never deasserts early.
- Level computation (macro-controlled, see Configuration):
  - rbin = Gray-to-binary of wq2_rptr, combinational XOR prefix from the MSB.
  - wlevel <= wbinnext - rbin, modulo 2^(ASIZE+1).
  - walmost_full <= ((wbinnext - rbin) >= 2^ASIZE - AF_MARGIN).
  - wlevel and walmost_full are computed from the same wbinnext and wq2_rptr as wfull, so all three are coherent in every cycle.
- Wrap-around: pointer 2^(ASIZE+1)-1 increments to 0. Full and level stay correct across the wrap because the comparison uses the extra MSB and modulo arithmetic.

## Timing
- Reset (asynchronous, whenever wrst_n=0, including mid-operation): wbin=0, waddr=0, wptr=0, wfull=0, wovf=0, wlevel=0, walmost_full=0.
- Outputs are valid on the first wclk edge after reset release.
- Latency: an accepted write at edge N updates waddr, wptr and wlevel at edge N.
- The write that fills the FIFO raises wfull at that same edge, so the next cycle's winc is already blocked.
- A wq2_rptr change is reflected in wfull, wlevel and walmost_full one wclk later.
- All outputs are registered, except waddr, which decodes wbin directly.
- wptr changes by at most one Gray bit per wclk.

## Configuration
- Macro: WPTR_FULL_LEVEL_EN.
- Defined: the Gray-to-binary converter, subtractor, wlevel register and walmost_full register are built as described above.
- Undefined: that logic is removed, wlevel is tied to 0 and walmost_full is driven by wfull.
- wptr, waddr, wfull and wovf behave identically in both builds.

## Test plan
All scenarios use ASIZE=4 and AF_MARGIN=2.
- Reset: assert wrst_n=0 with winc=1 -> all outputs are 0 immediately, and stay 0 until wrst_n rises.
- Fill: wq2_rptr=0, 16 consecutive winc -> wfull=1 at the 16th edge; waddr=0, wptr=5'b11000, wlevel=16.
- Overflow: with the FIFO full, apply winc=1 for 1 cycle -> waddr, wptr and wlevel unchanged; wovf=1. Then wovf_clr=1 with winc=1 while still full -> wovf stays 1. Then wovf_clr=1 with winc=0 -> wovf=0.
- Drain: with the FIFO full, set wq2_rptr=5'b00001 (binary 1) -> next edge wfull=0, wlevel=15, walmost_full=1.
- Almost-full: wq2_rptr=0, write 13 times -> walmost_full=0, wlevel=13. One more write -> walmost_full=1, wlevel=14.
- Wrap: preload by writing and reading 30 entries (wq2_rptr tracking gray(30)), then write 4 more -> wbin wraps from 31 to 0; wlevel=4, wfull=0, and no spurious wfull.
